// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: add/sub split into STAGES ripple slices with registered carries and valid/ready flow
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic              en;
  logic [STAGES-1:0] v, v_in, c, c_in, c_nx;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  s [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic [CHUNK:0]    t;
  assign en = out_ready || !out_valid;
  assign in_ready = en;
  // each slice adds its own chunk using the carry registered by the slice below; no path crosses slices
  always_comb begin
    t = '0;
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = cin ^ sub;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      a_in[i] = ra[i-1];
      b_in[i] = rb[i-1];
      c_in[i] = c[i-1];
      s_in[i] = s[i-1];
      v_in[i] = v[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      t = {1'b0, a_in[i][i*CHUNK +: CHUNK]} + {1'b0, b_in[i][i*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_in[i]};
      s_nx[i] = s_in[i];
      s_nx[i][i*CHUNK +: CHUNK] = t[CHUNK-1:0];
      c_nx[i] = t[CHUNK];
    end
  end
  // whole pipeline advances together on en, bubbles included, so a stall freezes every stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      c <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ra[i] <= '0;
        rb[i] <= '0;
        s[i] <= '0;
      end
    end else if (en) begin
      v <= v_in;
      c <= c_nx;
      for (int i = 0; i < STAGES; i++) begin
        ra[i] <= a_in[i];
        rb[i] <= b_in[i];
        s[i] <= s_nx[i];
      end
    end
  assign out_valid = v[L];
  assign sum = s[L];
  assign cout = c[L];
  assign ovf = (ra[L][WIDTH-1] == rb[L][WIDTH-1]) && (s[L][WIDTH-1] != ra[L][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed vectors plus randomized streams against an arithmetic reference model
module tb_pipelined_carry_adder;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] a = 0;
  logic [7:0] b = 0;
  logic       cin = 0;
  logic       sub = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  int total = 0;
  int bad = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [9:0] q [$];
  logic       hold = 0;
  logic [9:0] held = 0;

  pipelined_carry_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  // reference: plain integer arithmetic, returns {cout, ovf, sum}
  function automatic logic [9:0] model(logic [7:0] x, logic [7:0] y, logic ci, logic sb);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int c = ci ? 1 : 0;
    int r = sb ? ux - uy - c : ux + uy + c;
    int rs = sb ? sx - sy - c : sx + sy + c;
    logic co = sb ? (r >= 0) : (r > 255);
    logic ov = (rs > 127) || (rs < -128);
    logic [7:0] lo = r[7:0];
    return {co, ov, lo};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [7:0] x, logic [7:0] y, logic ci, logic sb, logic vld);
    a = x;
    b = y;
    cin = ci;
    sub = sb;
    in_valid = vld;
  endtask

  // scoreboard sampled mid-cycle: the handshakes seen here complete at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", {22'd0, cout, ovf, sum}, {22'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          check("stream_result", {22'd0, cout, ovf, sum}, {22'd0, q.pop_front()});
          n_pop++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        n_push++;
      end
      hold = out_valid && !out_ready;
      held = {cout, ovf, sum};
    end
  end

  vec_t vt [8];

  initial begin
    int p0, cyc;
    logic [9:0] snap;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    out_ready = 0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1;
    step();
    step();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1);
      step();
      drive(0, 0, 0, 0, 0);
      check("lat_not_yet", {31'd0, out_valid}, 32'd0);
      step();
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_sum", {24'd0, sum}, {24'd0, vt[i].s});
      check("vec_cout", {31'd0, cout}, {31'd0, vt[i].co});
      check("vec_ovf", {31'd0, ovf}, {31'd0, vt[i].ov});
    end
    step();
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    step();
    check("stream_count", n_pop - p0, 32'd100);
    check("stream_drained", q.size(), 32'd0);
    out_ready = 0;
    drive(8'h12, 8'h34, 0, 0, 1);
    step();
    drive(8'h56, 8'h78, 1, 1, 1);
    step();
    drive(8'h9A, 8'hBC, 0, 0, 1);
    snap = {cout, ovf, sum};
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {22'd0, cout, ovf, sum}, {22'd0, snap});
      step();
    end
    check("bp_first_result", {22'd0, snap}, {22'd0, model(8'h12, 8'h34, 0, 0)});
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    step();
    step();
    step();
    check("bp_drained", q.size(), 32'd0);
    p0 = n_push;
    cyc = 0;
    while (n_push - p0 < 1000 && cyc < 20000) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 2) != 0;
      step();
      cyc++;
    end
    check("rand_accepted", n_push - p0 >= 1000, 32'd1);
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    check("rand_drained", q.size(), 32'd0);
    drive(8'h01, 8'h02, 0, 0, 1);
    step();
    drive(8'h03, 8'h04, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {24'd0, sum}, 32'd0);
    check("mid_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
